// File: rtl/samp_pkg.sv
// Shared constants and payload types for the layer-2 window generator.
package samp_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IMG_W  = 14;
    localparam int unsigned IMG_H  = 14;
    localparam int unsigned K      = 3;

    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);

    typedef logic [DATA_W-1:0] pixel_t;
    // Element (r,c) sits at index r*K+c; r=0 is the oldest row, c=0 the oldest column.
    typedef pixel_t [K*K-1:0] window_t;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/samp_window_gen_if.sv
// Pooled-pixel input stream and KxK window output stream of the window generator.
interface samp_window_gen_if;
    import samp_pkg::*;

    logic    Input_Reset;
    pixel_t  Input_Pixel;
    logic    Input_Valid;
    logic    Input_Finish;
    window_t Window_Data;
    logic    Window_Valid;
    logic    Window_Finish;

    // master drives pixels and consumes windows; slave is the generator itself
    modport master (
        output Input_Reset, Input_Pixel, Input_Valid, Input_Finish,
        input  Window_Data, Window_Valid, Window_Finish
    );

    modport slave (
        input  Input_Reset, Input_Pixel, Input_Valid, Input_Finish,
        output Window_Data, Window_Valid, Window_Finish
    );

endinterface

// File: rtl/samp_line_delay.sv
// One image-row delay line: DEPTH-entry pixel shift register advancing on en.
module samp_line_delay #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 14
) (
    input  logic              h_clk,
    input  logic              h_reset,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DEPTH*DATA_W-1:0] sr_q;

    always_ff @(posedge h_clk or posedge h_reset) begin
        if (h_reset) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q <= {sr_q[(DEPTH-1)*DATA_W-1:0], din};
        end
    end

    // Oldest entry: the pixel accepted DEPTH enables ago, i.e. same column one row up.
    assign dout = sr_q[DEPTH*DATA_W-1 -: DATA_W];

endmodule

// File: rtl/samp_window_gen.sv
// Raster-stream to KxK sliding-window generator between the pooling layer and the layer-2 conv engine.
module samp_window_gen
    import samp_pkg::*;
(
    input  logic              h_clk,
    input  logic              h_reset,
    samp_window_gen_if.slave  bus
);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    pixel_t           tap [K-1];
    pixel_t           din [K-1];
    window_t          win_q;
    window_t          win_next;
    logic             valid_q;
    logic             finish_q;
    logic             shift_en;
    logic             col_last;
    logic             at_last;
    logic             in_window;

    assign shift_en  = bus.Input_Valid && !bus.Input_Reset;
    assign col_last  = (col_q == COL_W'(IMG_W - 1));
    assign at_last   = col_last && (row_q == ROW_W'(IMG_H - 1));
    assign in_window = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

    // Chain of K-1 row buffers; line j outputs the pixel j+1 rows above the current one.
    for (genvar j = 0; j < K - 1; j++) begin : g_line
        if (j == 0) begin : g_head
            assign din[j] = bus.Input_Pixel;
        end else begin : g_chain
            assign din[j] = tap[j-1];
        end
        samp_line_delay #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_line (
            .h_clk   (h_clk),
            .h_reset (h_reset),
            .en      (shift_en),
            .din     (din[j]),
            .dout    (tap[j])
        );
    end

    // Window shifts left one column; the new right column is oldest row first, live pixel last.
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            if (c < K - 1) begin : g_shift
                assign win_next[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
            end else if (r < K - 1) begin : g_tap
                assign win_next[win_idx(r, c)] = tap[K-2-r];
            end else begin : g_live
                assign win_next[win_idx(r, c)] = bus.Input_Pixel;
            end
        end
    end

    // Raster position of the next pixel; a soft clear or early finish restarts the frame.
    always_ff @(posedge h_clk or posedge h_reset) begin
        if (h_reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (bus.Input_Reset || bus.Input_Finish) begin
            col_q <= '0;
            row_q <= '0;
        end else if (bus.Input_Valid) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= at_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Window register and the one-cycle valid/finish pulses.
    always_ff @(posedge h_clk or posedge h_reset) begin
        if (h_reset) begin
            win_q    <= '0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
        end else if (bus.Input_Reset) begin
            win_q    <= '0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            valid_q  <= bus.Input_Valid && in_window;
            finish_q <= (bus.Input_Valid && at_last) || bus.Input_Finish;
            if (bus.Input_Valid) begin
                win_q <= win_next;
            end
        end
    end

    assign bus.Window_Data   = win_q;
    assign bus.Window_Valid  = valid_q;
    assign bus.Window_Finish = finish_q;

endmodule
